// File: rtl/alu_op_sequencer.sv
// Initiator side of the ALU control interface: issues a one-hot op with operands, waits the settle time, captures Z.
// Optional result flags are built only when ALU_RESULT_FLAGS_EN is defined; otherwise zero_flag/neg_flag are tied 0.
module alu_op_sequencer #(
    parameter int BITS       = 32,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [3:0]        opcode,
    input  logic [BITS-1:0]   a_in,
    input  logic [BITS-1:0]   b_in,
    output logic [11:0]       ctrl_signal,
    output logic [BITS-1:0]   X,
    output logic [BITS-1:0]   Y,
    input  logic [2*BITS-1:0] operationResult,
    output logic [BITS-1:0]   z_lo,
    output logic [BITS-1:0]   z_hi,
    output logic              busy,
    output logic              done,
    output logic              illegal_op,
    output logic              zero_flag,
    output logic              neg_flag
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_load;
    logic             capture;
    logic             wide_op;

    // Multiply and divide produce a full double-width result; everything else only uses the low half.
    assign wide_op = ctrl_signal[2] | ctrl_signal[3];
    assign capture = (state == EXEC) && (count == CNT_W'(1));

    always_comb begin
        count_load = CNT_W'(1);
        if (opcode == 4'd2)
            count_load = CNT_W'(MUL_CYCLES);
        else if (opcode == 4'd3)
            count_load = CNT_W'(DIV_CYCLES);
    end

    // NOTE: every register below is updated with <= so all state advances together on the edge.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            count       <= '0;
            ctrl_signal <= '0;
            X           <= '0;
            Y           <= '0;
            z_lo        <= '0;
            z_hi        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            done       <= 1'b0;
            illegal_op <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (opcode <= 4'd11) begin
                            X           <= a_in;
                            Y           <= b_in;
                            ctrl_signal <= 12'd1 << opcode;
                            count       <= count_load;
                            state       <= EXEC;
                        end else begin
                            // Illegal opcodes never drive the ALU and leave Z untouched.
                            illegal_op <= 1'b1;
                            done       <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                EXEC: begin
                    count <= count - CNT_W'(1);
                    if (capture) begin
                        z_lo        <= operationResult[BITS-1:0];
                        z_hi        <= wide_op ? operationResult[2*BITS-1:BITS] : '0;
                        ctrl_signal <= '0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy        <= 1'b0;
                    ctrl_signal <= '0;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_RESULT_FLAGS_EN
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            zero_flag <= 1'b0;
            neg_flag  <= 1'b0;
        end else if (capture) begin
            zero_flag <= wide_op ? (operationResult == '0) : (operationResult[BITS-1:0] == '0);
            neg_flag  <= wide_op ? operationResult[2*BITS-1] : operationResult[BITS-1];
        end
    end
`else
    assign zero_flag = 1'b0;
    assign neg_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer, with a behavioural combinational ALU model.
module tb_alu_op_sequencer;

    localparam int BITS = 32;
    localparam int MUL_CYCLES = 4;
    localparam int DIV_CYCLES = 8;

    logic              clock = 1'b0;
    logic              clear = 1'b1;
    logic              start = 1'b0;
    logic [3:0]        opcode = 4'd0;
    logic [BITS-1:0]   a_in = '0;
    logic [BITS-1:0]   b_in = '0;
    logic [11:0]       ctrl_signal;
    logic [BITS-1:0]   X;
    logic [BITS-1:0]   Y;
    logic [2*BITS-1:0] operationResult;
    logic [BITS-1:0]   z_lo;
    logic [BITS-1:0]   z_hi;
    logic              busy;
    logic              done;
    logic              illegal_op;
    logic              zero_flag;
    logic              neg_flag;

    int vectors = 0;
    int miscompares = 0;

    alu_op_sequencer #(
        .BITS(BITS),
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) dut (
        .clock(clock),
        .clear(clear),
        .start(start),
        .opcode(opcode),
        .a_in(a_in),
        .b_in(b_in),
        .ctrl_signal(ctrl_signal),
        .X(X),
        .Y(Y),
        .operationResult(operationResult),
        .z_lo(z_lo),
        .z_hi(z_hi),
        .busy(busy),
        .done(done),
        .illegal_op(illegal_op),
        .zero_flag(zero_flag),
        .neg_flag(neg_flag)
    );

    always #5 clock = ~clock;

    // Combinational ALU model; divide returns {remainder, quotient}.
    always_comb begin
        operationResult = '0;
        case (ctrl_signal)
            12'h001: operationResult = {32'h0, X + Y};
            12'h002: operationResult = {32'h0, X - Y};
            12'h004: operationResult = 64'(X) * 64'(Y);
            12'h008: operationResult = (Y != 0) ? {X % Y, X / Y} : 64'h0;
            12'h010: operationResult = {32'h0, X >> Y[4:0]};
            12'h020: operationResult = {32'h0, X << Y[4:0]};
            12'h040: operationResult = {32'h0, (X >> Y[4:0]) | (X << (6'd32 - {1'b0, Y[4:0]}))};
            12'h080: operationResult = {32'h0, (X << Y[4:0]) | (X >> (6'd32 - {1'b0, Y[4:0]}))};
            12'h100: operationResult = {32'h0, X & Y};
            12'h200: operationResult = {32'h0, X | Y};
            12'h400: operationResult = {32'h0, -X};
            12'h800: operationResult = {32'h0, ~X};
            default: operationResult = '0;
        endcase
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one op, check the EXEC-phase drive every cycle, the done latency and the one-cycle done pulse.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [11:0] exp_ctrl, input logic exp_ill,
                         input string name);
        int lat;
        start = 1'b1; opcode = op; a_in = a; b_in = b;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 50) begin
            if ({busy, ctrl_signal, X, Y} !== {1'b1, exp_ctrl, a, b}) begin
                $display("FAIL %s exec drive: got busy=%b ctrl=%h X=%h Y=%h, want busy=1 ctrl=%h X=%h Y=%h",
                         name, busy, ctrl_signal, X, Y, exp_ctrl, a, b);
                miscompares++;
            end
            vectors++;
            tick();
            lat++;
        end
        if (lat !== exp_lat || done !== 1'b1) begin
            $display("FAIL %s latency: got done=%b after %0d edges, want done=1 after %0d", name, done, lat, exp_lat);
            miscompares++;
        end
        vectors++;
        if ({busy, ctrl_signal, illegal_op} !== {1'b1, 12'h000, exp_ill}) begin
            $display("FAIL %s done cycle: got busy=%b ctrl=%h illegal=%b, want busy=1 ctrl=000 illegal=%b",
                     name, busy, ctrl_signal, illegal_op, exp_ill);
            miscompares++;
        end
        vectors++;
        tick();
        if ({done, busy, illegal_op} !== 3'b000) begin
            $display("FAIL %s after done: got done=%b busy=%b illegal=%b, want 000", name, done, busy, illegal_op);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic check_z(input logic [31:0] hi, input logic [31:0] lo, input string name);
        if ({z_hi, z_lo} !== {hi, lo}) begin
            $display("FAIL %s result: got z_hi=%h z_lo=%h, want z_hi=%h z_lo=%h", name, z_hi, z_lo, hi, lo);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_reset();
        #1;
        if ({ctrl_signal, X, Y, z_lo, z_hi, busy, done, illegal_op, zero_flag, neg_flag} !== '0) begin
            $display("FAIL reset state: got ctrl=%h X=%h Y=%h z_lo=%h z_hi=%h busy=%b done=%b ill=%b zf=%b nf=%b, want all 0",
                     ctrl_signal, X, Y, z_lo, z_hi, busy, done, illegal_op, zero_flag, neg_flag);
            miscompares++;
        end
        vectors++;
        tick();
        tick();
        clear = 1'b0;
        tick();
    endtask

    task automatic test_add();
        do_op(4'd0, 32'd5, 32'd7, 1, 12'h001, 1'b0, "add");
        check_z(32'h0, 32'd12, "add");
    endtask

    task automatic test_mul();
        do_op(4'd2, 32'h8000_0001, 32'd2, MUL_CYCLES, 12'h004, 1'b0, "mul");
        check_z(32'h1, 32'h2, "mul");
    endtask

    task automatic test_illegal();
        do_op(4'd13, 32'hDEAD_BEEF, 32'h1234_5678, 0, 12'h000, 1'b1, "illegal");
        check_z(32'h1, 32'h2, "illegal keeps z");
        if ({X, Y} !== {32'h8000_0001, 32'd2}) begin
            $display("FAIL illegal operands: got X=%h Y=%h, want X=80000001 Y=00000002", X, Y);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_logic_ops();
        do_op(4'd5, 32'd1, 32'd4, 1, 12'h020, 1'b0, "shl");
        check_z(32'h0, 32'd16, "shl");
        do_op(4'd8, 32'h0000_F0F0, 32'h0000_FF00, 1, 12'h100, 1'b0, "and");
        check_z(32'h0, 32'h0000_F000, "and");
        do_op(4'd3, 32'd100, 32'd7, DIV_CYCLES, 12'h008, 1'b0, "div");
        check_z(32'd2, 32'd14, "div");
    endtask

    task automatic test_back_to_back();
        int lat;
        int extra;
        start = 1'b1; opcode = 4'd3; a_in = 32'd200; b_in = 32'd9;
        tick();
        lat = 0;
        while (!done && lat < 50) begin
            if (lat == 2) begin
                start = 1'b1; opcode = 4'd0; a_in = 32'd1; b_in = 32'd1;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        if (lat !== DIV_CYCLES || done !== 1'b1) begin
            $display("FAIL overlap latency: got done=%b after %0d edges, want done=1 after %0d", done, lat, DIV_CYCLES);
            miscompares++;
        end
        vectors++;
        check_z(32'd2, 32'd22, "overlap div");
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) extra++;
        end
        if (extra !== 0) begin
            $display("FAIL overlap ignored: got %0d busy/done cycles after completion, want 0", extra);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_hold_start();
        int lat;
        start = 1'b1; opcode = 4'd0; a_in = 32'd2; b_in = 32'd3;
        tick();
        lat = 0;
        while (!done && lat < 50) begin
            tick();
            lat++;
        end
        tick();
        if (busy !== 1'b0) begin
            $display("FAIL hold idle gap: got busy=%b, want 0", busy);
            miscompares++;
        end
        vectors++;
        tick();
        start = 1'b0;
        if ({busy, ctrl_signal} !== {1'b1, 12'h001}) begin
            $display("FAIL hold reaccept: got busy=%b ctrl=%h, want busy=1 ctrl=001", busy, ctrl_signal);
            miscompares++;
        end
        vectors++;
        lat = 0;
        while (!done && lat < 50) begin
            tick();
            lat++;
        end
        if (lat !== 1) begin
            $display("FAIL hold second op latency: got %0d, want 1", lat);
            miscompares++;
        end
        vectors++;
        tick();
        check_z(32'h0, 32'd5, "hold add");
    endtask

    task automatic test_flags();
        logic exp_zero;
        logic exp_neg;
        do_op(4'd1, 32'd3, 32'd3, 1, 12'h002, 1'b0, "sub zero");
`ifdef ALU_RESULT_FLAGS_EN
        exp_zero = 1'b1; exp_neg = 1'b0;
`else
        exp_zero = 1'b0; exp_neg = 1'b0;
`endif
        if ({zero_flag, neg_flag} !== {exp_zero, exp_neg}) begin
            $display("FAIL flags 3-3: got zf=%b nf=%b, want zf=%b nf=%b", zero_flag, neg_flag, exp_zero, exp_neg);
            miscompares++;
        end
        vectors++;
        do_op(4'd1, 32'd3, 32'd5, 1, 12'h002, 1'b0, "sub neg");
        check_z(32'h0, 32'hFFFF_FFFE, "sub neg");
`ifdef ALU_RESULT_FLAGS_EN
        exp_zero = 1'b0; exp_neg = 1'b1;
`else
        exp_zero = 1'b0; exp_neg = 1'b0;
`endif
        if ({zero_flag, neg_flag} !== {exp_zero, exp_neg}) begin
            $display("FAIL flags 3-5: got zf=%b nf=%b, want zf=%b nf=%b", zero_flag, neg_flag, exp_zero, exp_neg);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_reset_mid_op();
        int seen;
        start = 1'b1; opcode = 4'd3; a_in = 32'd50; b_in = 32'd5;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        clear = 1'b1;
        #1;
        if ({ctrl_signal, X, Y, z_lo, z_hi, busy, done, illegal_op, zero_flag, neg_flag} !== '0) begin
            $display("FAIL async clear: got ctrl=%h X=%h Y=%h z_lo=%h z_hi=%h busy=%b done=%b ill=%b zf=%b nf=%b, want all 0",
                     ctrl_signal, X, Y, z_lo, z_hi, busy, done, illegal_op, zero_flag, neg_flag);
            miscompares++;
        end
        vectors++;
        #1;
        clear = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) seen++;
        end
        if (seen !== 0) begin
            $display("FAIL abort no done: got %0d busy/done cycles, want 0", seen);
            miscompares++;
        end
        vectors++;
        do_op(4'd0, 32'd20, 32'd22, 1, 12'h001, 1'b0, "add after clear");
        check_z(32'h0, 32'd42, "add after clear");
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_illegal();
        test_logic_ops();
        test_back_to_back();
        test_hold_start();
        test_flags();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
